peaks_readout_fifo: RTL and testbench
=====================================

Name: peaks_readout_fifo

Overview:
- Sits between the peak finder and the HPS driver read bus in the FFT accelerator top level.
- Captures each complete peak record (time counter, peak frequencies, peak amplitudes) when the peak finder asserts valid, and queues it in a record FIFO.
- Presents the head record as a stable byte-addressed window, so software reads never tear across updates.
- Software pops a record explicitly with a write, which removes the need for address-range snapshot gating.

Parameters:
DEPTH, 8, number of records held (power of two, ≥2)
PEAKS, 6, peaks per record
FREQ_WIDTH, 8, bits per peak frequency
AMPL_WIDTH, 16, bits per peak amplitude (upper bits of the peak finder amplitude)
TIME_WIDTH, 32, bits of time counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
valid_in  input  1  single-cycle pulse: record inputs valid this cycle
counter_in  input  TIME_WIDTH  time counter of record
freqs_in  input  PEAKS*FREQ_WIDTH  peak i at bits [i*FREQ_WIDTH +: FREQ_WIDTH]
amps_in  input  PEAKS*AMPL_WIDTH  peak i at bits [i*AMPL_WIDTH +: AMPL_WIDTH]
chipselect  input  1  bus select
write  input  1  bus write strobe (qualified by chipselect)
address  input  8  bus byte address
writedata  input  8  bus write data (ignored; address selects the command)
readdata  output  8  registered read data
irq_nonempty  output  1  high while count > 0

Behaviour:
- Reset (asynchronous assert, synchronous release on clk): wr_ptr=rd_ptr=0, count=0, overflow=0, drop_count=0, readdata=0, irq_nonempty=0. Storage contents are don't-care.
- Push: on a valid_in=1 cycle, if count<DEPTH, write the full record into entry wr_ptr. wr_ptr increments, wrapping modulo DEPTH.
- Full push: valid_in while count==DEPTH and no pop in the same cycle:
  - the record is dropped;
  - overflow becomes 1 (sticky);
  - drop_count increments, saturating at 255.
- Pop: chipselect&&write&&address==8'h21 with count>0 advances rd_ptr, wrapping modulo DEPTH.
- Empty pop: a pop with count==0 is ignored, with no error.
- Simultaneous push and pop: both take effect and count is unchanged. This includes the full case, where the push is accepted and not dropped.
- Clear overflow: chipselect&&write&&address==8'h22 clears overflow and drop_count. If a drop occurs in the same cycle, the clear wins for drop_count, which is left at 0, but overflow is set to 1.
- Writes to any other address: no effect.
- Read latency: readdata is updated every clk, whatever the chipselect value, from address sampled that cycle. Data is valid one cycle after the address is presented.
- Read map, with head = entry rd_ptr (byte map defined for default parameters):
  - 0x00–0x03: counter, MSB first
  - 0x04–0x09: freq[0]..freq[5]
  - 0x0A–0x15: amp[i] as 2 bytes MSB first, at 0x0A+2i
  - 0x20: count (zero-extended)
  - 0x21: {overflow, 6'b0, count==DEPTH}
  - 0x22: drop_count
  - 0xFF: ID constant 8'hA5
  - all others: 0
- Empty FIFO: record addresses 0x00–0x15 read 0.
- Head stability: the head record does not change until a pop. Pushes never alter the head entry while count>0, so reads are tear-free.
- A pop and a read in the same cycle return the pre-pop head byte.
- irq_nonempty is registered, equal to (count_next>0), and updates in the same cycle as count.
- Count width: clog2(DEPTH)+1 bits; must represent DEPTH exactly.

Test Plan:
1. Reset then read 0x20, 0x21, 0x22, 0xFF -> readdata 0, 0, 0, 0xA5 (one-cycle latency); read 0x00 -> 0.
2. Push counter=0x12345678, freqs 1..6, amps 0x1111·(i+1) -> irq_nonempty=1 next cycle. Then:
   - reads 0x00..0x03 -> 12,34,56,78
   - 0x04..0x09 -> 1..6
   - 0x0A,0x0B -> 11,11
   - 0x14,0x15 -> 66,66
   - pop -> 0x20 reads 0, irq_nonempty=0
3. Push 10 records (counters 0..9) with no pops -> 0x20=8, 0x21=0x81, 0x22=2. Popping 8 times yields counters 0..7 in order, showing wrap-around.
4. With FIFO full, pulse valid_in and pop in the same cycle -> count stays 8, drop_count unchanged, and the new record appears last after 7 further pops.
5. Pop on empty -> count stays 0. Then write 0x22 -> 0x21 and 0x22 read 0. Write 0x22 coincident with a full-drop -> 0x21 bit7=1, 0x22=0.
6. Assert reset low mid-stream with 3 records queued and readdata nonzero -> outputs 0 immediately, without waiting for clk; after release, 0x20 reads 0.

Source files
------------

// File: rtl/peaks_readout_fifo.sv
// rtl/peaks_readout_fifo.sv - peak record FIFO with a tear-free byte-addressed head window
// Records are stored big-endian so byte address N maps straight onto byte N of the stored vector.
module peaks_readout_fifo #(
  parameter int DEPTH      = 8,
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 8,
  parameter int AMPL_WIDTH = 16,
  parameter int TIME_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [TIME_WIDTH-1:0]       counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0] amps_in,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [7:0]                  address,
  input  logic [7:0]                  writedata,
  output logic [7:0]                  readdata,
  output logic                        irq_nonempty
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int REC_W     = TIME_WIDTH + PEAKS * (FREQ_WIDTH + AMPL_WIDTH);
  localparam int REC_BYTES = REC_W / 8;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             pop, push, drop, clr;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  always_comb begin
    rec_in = '0;
    rec_in[REC_W-1 -: TIME_WIDTH] = counter_in;
    for (int i = 0; i < PEAKS; i++) begin
      rec_in[REC_W-1-TIME_WIDTH-i*FREQ_WIDTH -: FREQ_WIDTH] = freqs_in[i*FREQ_WIDTH +: FREQ_WIDTH];
      rec_in[REC_W-1-TIME_WIDTH-PEAKS*FREQ_WIDTH-i*AMPL_WIDTH -: AMPL_WIDTH] =
        amps_in[i*AMPL_WIDTH +: AMPL_WIDTH];
    end
  end

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  always_comb begin
    pop  = chipselect && write && (address == 8'h21) && (count_q != '0);
    clr  = chipselect && write && (address == 8'h22);
    push = valid_in && ((count_q != FULL) || pop);
    drop = valid_in && !push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = drop | (overflow_q & ~clr);
    drop_d     = drop_q;
    if (clr)
      drop_d = 8'h00;
    else if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 8'h01;

    irq_d = (count_d != '0);
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    readdata_d = 8'h00;
    for (int b = 0; b < REC_BYTES; b++) begin
      if (address == 8'(b) && count_q != '0)
        readdata_d = head[REC_W-1-8*b -: 8];
    end
    case (address)
      8'h20:   readdata_d = {{(8-CW){1'b0}}, count_q};
      8'h21:   readdata_d = {overflow_q, 6'b0, count_q == FULL};
      8'h22:   readdata_d = drop_q;
      8'hFF:   readdata_d = 8'hA5;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= rec_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'h00;
      readdata_q <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq_nonempty = irq_q;

endmodule

// File: tb/tb_peaks_readout_fifo.sv
// tb/tb_peaks_readout_fifo.sv - directed and random checks of peaks_readout_fifo against a queue model
module tb_peaks_readout_fifo;

  typedef struct packed {
    logic [31:0]      cnt;
    logic [5:0][7:0]  f;
    logic [5:0][15:0] a;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] counter_in;
  logic [47:0] freqs_in;
  logic [95:0] amps_in;
  logic        chipselect;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        irq_nonempty;

  rec_t       q[$];
  bit         ovf;
  int         drops;
  int         n_checks;
  int         n_pass;
  logic [7:0] last_rd;

  peaks_readout_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .counter_in   (counter_in),
    .freqs_in     (freqs_in),
    .amps_in      (amps_in),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq_nonempty (irq_nonempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t rand_rec(input logic [31:0] c);
    rec_t r;
    r.cnt = c;
    for (int i = 0; i < 6; i++) begin
      r.f[i] = 8'($urandom);
      r.a[i] = 16'($urandom);
    end
    return r;
  endfunction

  function automatic logic [7:0] model_byte(input int a);
    rec_t h;
    int   k;
    if (a <= 8'h15) begin
      if (q.size() == 0) return 8'h00;
      h = q[0];
      if (a < 4) return 8'(h.cnt >> (8 * (3 - a)));
      if (a < 10) return h.f[a-4];
      k = (a - 10) / 2;
      return ((a - 10) % 2 == 0) ? h.a[k][15:8] : h.a[k][7:0];
    end
    case (a)
      8'h20:   return 8'(q.size());
      8'h21:   return {ovf, 6'b0, q.size() == 8};
      8'h22:   return 8'(drops);
      8'hFF:   return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cycle(input logic v, input rec_t r, input logic cs, input logic wr, input logic [7:0] addr);
    logic [7:0] exp;
    bit         pop_eff;
    bit         push_ok;
    bit         clr;
    @(negedge clk);
    valid_in   = v;
    counter_in = r.cnt;
    for (int i = 0; i < 6; i++) begin
      freqs_in[i*8 +: 8]  = r.f[i];
      amps_in[i*16 +: 16] = r.a[i];
    end
    chipselect = cs;
    write      = wr;
    address    = addr;
    writedata  = 8'($urandom);
    exp        = model_byte(int'(addr));
    @(posedge clk);
    #1;
    pop_eff = cs && wr && addr == 8'h21 && q.size() > 0;
    clr     = cs && wr && addr == 8'h22;
    push_ok = v && (q.size() < 8 || pop_eff);
    if (pop_eff) void'(q.pop_front());
    if (push_ok) q.push_back(r);
    if (v && !push_ok) begin
      ovf   = 1'b1;
      drops = clr ? 0 : (drops < 255 ? drops + 1 : 255);
    end else if (clr) begin
      ovf   = 1'b0;
      drops = 0;
    end
    last_rd = readdata;
    check($sformatf("rd@%02h", addr), readdata, exp);
    check("irq", irq_nonempty, q.size() != 0);
    valid_in = 1'b0;
    write    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr);
    cycle(1'b0, '0, 1'b1, 1'b0, addr);
  endtask

  task automatic push(input rec_t r);
    cycle(1'b1, r, 1'b1, 1'b0, 8'h20);
  endtask

  task automatic pop();
    cycle(1'b0, '0, 1'b1, 1'b1, 8'h21);
  endtask

  initial begin
    rec_t ra;
    n_checks = 0;
    n_pass   = 0;
    ovf      = 1'b0;
    drops    = 0;
    reset = 1'b1; valid_in = 1'b0; counter_in = '0; freqs_in = '0; amps_in = '0;
    chipselect = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    #1 reset = 1'b0;
    #1;
    check("rst_readdata", readdata, 8'h00);
    check("rst_irq", irq_nonempty, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    rd(8'h20); check("t1_count", last_rd, 8'h00);
    rd(8'h21); check("t1_status", last_rd, 8'h00);
    rd(8'h22); check("t1_drops", last_rd, 8'h00);
    rd(8'hFF); check("t1_id", last_rd, 8'hA5);
    rd(8'h00); check("t1_empty_rec", last_rd, 8'h00);

    ra.cnt = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      ra.f[i] = 8'(i + 1);
      ra.a[i] = 16'(16'h1111 * (i + 1));
    end
    push(ra);
    check("t2_irq", irq_nonempty, 1'b1);
    for (int a = 0; a <= 8'h15; a++) rd(8'(a));
    rd(8'h00); check("t2_b00", last_rd, 8'h12);
    rd(8'h03); check("t2_b03", last_rd, 8'h78);
    rd(8'h09); check("t2_b09", last_rd, 8'h06);
    rd(8'h0A); check("t2_b0a", last_rd, 8'h11);
    rd(8'h15); check("t2_b15", last_rd, 8'h66);
    pop();
    rd(8'h20); check("t2_count_after_pop", last_rd, 8'h00);
    check("t2_irq_after_pop", irq_nonempty, 1'b0);

    for (int i = 0; i < 10; i++) push(rand_rec(32'(i)));
    rd(8'h20); check("t3_count", last_rd, 8'h08);
    rd(8'h21); check("t3_status", last_rd, 8'h81);
    rd(8'h22); check("t3_drops", last_rd, 8'h02);
    for (int i = 0; i < 8; i++) begin
      rd(8'h03); check("t3_order", last_rd, 8'(i));
      pop();
    end

    for (int i = 0; i < 8; i++) push(rand_rec(32'h100 + 32'(i)));
    cycle(1'b1, rand_rec(32'hAA), 1'b1, 1'b1, 8'h21);
    rd(8'h20); check("t4_count", last_rd, 8'h08);
    rd(8'h22); check("t4_drops", last_rd, 8'h02);
    for (int i = 0; i < 7; i++) pop();
    rd(8'h03); check("t4_last", last_rd, 8'hAA);
    rd(8'h20); check("t4_count_one", last_rd, 8'h01);
    pop();

    pop();
    rd(8'h20); check("t5_empty_pop", last_rd, 8'h00);
    cycle(1'b0, '0, 1'b1, 1'b1, 8'h22);
    rd(8'h21); check("t5_clr_status", last_rd, 8'h00);
    rd(8'h22); check("t5_clr_drops", last_rd, 8'h00);
    for (int i = 0; i < 8; i++) push(rand_rec(32'h200 + 32'(i)));
    cycle(1'b1, rand_rec(32'hBB), 1'b1, 1'b1, 8'h22);
    rd(8'h21); check("t5_drop_clr_status", last_rd, 8'h81);
    rd(8'h22); check("t5_drop_clr_drops", last_rd, 8'h00);

    for (int i = 0; i < 5; i++) pop();
    rd(8'h20); check("t6_count_before", last_rd, 8'h03);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async_readdata", readdata, 8'h00);
    check("t6_async_irq", irq_nonempty, 1'b0);
    q.delete();
    ovf   = 1'b0;
    drops = 0;
    @(negedge clk);
    reset = 1'b1;
    rd(8'h20); check("t6_count_after", last_rd, 8'h00);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] addr;
      int         sel;
      sel = int'($urandom % 8);
      if (sel < 3)       addr = 8'h21;
      else if (sel == 3) addr = 8'h22;
      else if (sel < 6)  addr = 8'($urandom_range(0, 8'h23));
      else if (sel == 6) addr = 8'hFF;
      else               addr = 8'($urandom_range(0, 255));
      cycle(1'($urandom % 2), rand_rec($urandom), 1'($urandom % 8 != 0), 1'($urandom % 2), addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
